// File: rtl/riscv_stream_mmio.sv
// Memory-mapped stream I/O for the picorv32 native bus: per-channel TX/RX FIFOs plus STATUS.
// Define STREAM_MMIO_BLOCKING_EN to stall full-TX stores and empty-RX loads instead of flagging.
module riscv_stream_mmio #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         io_sel,
  output logic                         io_ready,
  output logic [31:0]                  io_rdata,
  input  logic [NUM_CH-1:0]            val_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic [NUM_CH-1:0]            ready_upward,
  output logic [NUM_CH-1:0]            val_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  input  logic [NUM_CH-1:0]            ready_downward,
  output logic [NUM_CH-1:0]            irq_rx
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam int unsigned     CntW    = PtrW + 1;
  localparam int unsigned     ChW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0]     WinSize = 32'(16 * NUM_CH);
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StResp} state_e;
  typedef logic [DATA_WIDTH-1:0] word_t;

  state_e         state_q, state_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [ChW-1:0] act_ch_q, act_ch_d;
  word_t          act_wdata_q, act_wdata_d;
  logic           act_tx_push_q, act_tx_push_d;
  logic           act_rx_pop_q, act_rx_pop_d;
  logic           act_set_ovf_q, act_set_ovf_d;
  logic           act_set_udf_q, act_set_udf_d;
  logic           act_clr_ovf_q, act_clr_ovf_d;
  logic           act_clr_udf_q, act_clr_udf_d;

  word_t           tx_mem_q  [NUM_CH][DEPTH];
  word_t           tx_mem_d  [NUM_CH][DEPTH];
  word_t           rx_mem_q  [NUM_CH][DEPTH];
  word_t           rx_mem_d  [NUM_CH][DEPTH];
  logic [PtrW-1:0] tx_wptr_q [NUM_CH];
  logic [PtrW-1:0] tx_wptr_d [NUM_CH];
  logic [PtrW-1:0] tx_rptr_q [NUM_CH];
  logic [PtrW-1:0] tx_rptr_d [NUM_CH];
  logic [PtrW-1:0] rx_wptr_q [NUM_CH];
  logic [PtrW-1:0] rx_wptr_d [NUM_CH];
  logic [PtrW-1:0] rx_rptr_q [NUM_CH];
  logic [PtrW-1:0] rx_rptr_d [NUM_CH];
  logic [CntW-1:0] tx_cnt_q  [NUM_CH];
  logic [CntW-1:0] tx_cnt_d  [NUM_CH];
  logic [CntW-1:0] rx_cnt_q  [NUM_CH];
  logic [CntW-1:0] rx_cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d, udf_q, udf_d;

  logic [NUM_CH-1:0] ch_hit, tx_push, tx_pop, rx_push, rx_pop;

  logic [31:0]    req_off;
  logic [ChW-1:0] req_ch;
  logic [1:0]     req_reg;
  logic           req_store;
  logic [31:0]    status_word;
  word_t          rx_head;
  logic           accept;

  // Address decode
  always_comb begin
    req_off   = mem_addr - BASE_ADDR;
    io_sel    = mem_valid && (mem_addr >= BASE_ADDR) && (req_off < WinSize);
    req_ch    = req_off[4 +: ChW];
    req_reg   = req_off[3:2];
    req_store = |mem_wstrb;
  end

  always_comb begin
    status_word        = '0;
    status_word[0]     = (rx_cnt_q[req_ch] != '0);
    status_word[1]     = (tx_cnt_q[req_ch] == Full);
    status_word[2]     = (tx_cnt_q[req_ch] == '0);
    status_word[3]     = ovf_q[req_ch];
    status_word[4]     = udf_q[req_ch];
    status_word[15:8]  = 8'(rx_cnt_q[req_ch]);
    status_word[23:16] = 8'(tx_cnt_q[req_ch]);
    rx_head            = rx_mem_q[req_ch][rx_rptr_q[req_ch]];
  end

  // Access FSM: decide in IDLE, acknowledge and commit the latched action in RESP
  always_comb begin
    state_d       = state_q;
    rdata_d       = '0;
    act_ch_d      = act_ch_q;
    act_wdata_d   = act_wdata_q;
    act_tx_push_d = 1'b0;
    act_rx_pop_d  = 1'b0;
    act_set_ovf_d = 1'b0;
    act_set_udf_d = 1'b0;
    act_clr_ovf_d = 1'b0;
    act_clr_udf_d = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (io_sel) begin
          accept      = 1'b1;
          act_ch_d    = req_ch;
          act_wdata_d = mem_wdata[DATA_WIDTH-1:0];
          unique case (req_reg)
            2'd0: begin
              if (req_store) begin
                if (tx_cnt_q[req_ch] == Full) begin
`ifdef STREAM_MMIO_BLOCKING_EN
                  accept = 1'b0;
`else
                  act_set_ovf_d = 1'b1;
`endif
                end else begin
                  act_tx_push_d = 1'b1;
                end
              end
            end
            2'd1: begin
              if (!req_store) begin
                if (rx_cnt_q[req_ch] == '0) begin
`ifdef STREAM_MMIO_BLOCKING_EN
                  accept = 1'b0;
`else
                  act_set_udf_d = 1'b1;
`endif
                end else begin
                  rdata_d      = 32'(rx_head);
                  act_rx_pop_d = 1'b1;
                end
              end
            end
            2'd2: begin
              if (req_store) begin
                act_clr_ovf_d = mem_wdata[3];
                act_clr_udf_d = mem_wdata[4];
              end else begin
                rdata_d = status_word;
              end
            end
            default: ;
          endcase
          if (accept) begin
            state_d = StResp;
          end else begin
            rdata_d       = '0;
            act_tx_push_d = 1'b0;
            act_rx_pop_d  = 1'b0;
            act_set_ovf_d = 1'b0;
            act_set_udf_d = 1'b0;
            act_clr_ovf_d = 1'b0;
            act_clr_udf_d = 1'b0;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign io_ready = (state_q == StResp);
  assign io_rdata = rdata_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      val_out[c]      = (tx_cnt_q[c] != '0);
      ready_upward[c] = (rx_cnt_q[c] != Full);
      irq_rx[c]       = (rx_cnt_q[c] != '0);
      dout[c*DATA_WIDTH +: DATA_WIDTH] = val_out[c] ? tx_mem_q[c][tx_rptr_q[c]] : '0;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit[c]  = (act_ch_q == ChW'(c));
      tx_push[c] = act_tx_push_q && ch_hit[c];
      tx_pop[c]  = val_out[c] && ready_downward[c];
      rx_push[c] = val_in[c] && ready_upward[c];
      rx_pop[c]  = act_rx_pop_q && ch_hit[c];
    end
  end

  // FIFO pointers/counts and sticky flags
  always_comb begin
    tx_mem_d  = tx_mem_q;
    rx_mem_d  = rx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (tx_push[c]) begin
        tx_mem_d[c][tx_wptr_q[c]] = act_wdata_q;
        tx_wptr_d[c]              = tx_wptr_q[c] + 1'b1;
      end
      if (tx_pop[c]) tx_rptr_d[c] = tx_rptr_q[c] + 1'b1;
      if (tx_push[c] && !tx_pop[c])      tx_cnt_d[c] = tx_cnt_q[c] + 1'b1;
      else if (!tx_push[c] && tx_pop[c]) tx_cnt_d[c] = tx_cnt_q[c] - 1'b1;

      if (rx_push[c]) begin
        rx_mem_d[c][rx_wptr_q[c]] = din[c*DATA_WIDTH +: DATA_WIDTH];
        rx_wptr_d[c]              = rx_wptr_q[c] + 1'b1;
      end
      if (rx_pop[c]) rx_rptr_d[c] = rx_rptr_q[c] + 1'b1;
      if (rx_push[c] && !rx_pop[c])      rx_cnt_d[c] = rx_cnt_q[c] + 1'b1;
      else if (!rx_push[c] && rx_pop[c]) rx_cnt_d[c] = rx_cnt_q[c] - 1'b1;

      if (act_set_ovf_q && ch_hit[c]) ovf_d[c] = 1'b1;
      if (act_clr_ovf_q && ch_hit[c]) ovf_d[c] = 1'b0;
      if (act_set_udf_q && ch_hit[c]) udf_d[c] = 1'b1;
      if (act_clr_udf_q && ch_hit[c]) udf_d[c] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      rdata_q       <= '0;
      act_ch_q      <= '0;
      act_wdata_q   <= '0;
      act_tx_push_q <= 1'b0;
      act_rx_pop_q  <= 1'b0;
      act_set_ovf_q <= 1'b0;
      act_set_udf_q <= 1'b0;
      act_clr_ovf_q <= 1'b0;
      act_clr_udf_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        tx_wptr_q[c] <= '0;
        tx_rptr_q[c] <= '0;
        rx_wptr_q[c] <= '0;
        rx_rptr_q[c] <= '0;
        tx_cnt_q[c]  <= '0;
        rx_cnt_q[c]  <= '0;
      end
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      act_ch_q      <= act_ch_d;
      act_wdata_q   <= act_wdata_d;
      act_tx_push_q <= act_tx_push_d;
      act_rx_pop_q  <= act_rx_pop_d;
      act_set_ovf_q <= act_set_ovf_d;
      act_set_udf_q <= act_set_udf_d;
      act_clr_ovf_q <= act_clr_ovf_d;
      act_clr_udf_q <= act_clr_udf_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
    end
  end

  // Storage needs no reset; counts gate every visible use
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_riscv_stream_mmio.sv
// Self-checking bench for riscv_stream_mmio (NUM_CH=4, DEPTH=8); scoreboard queues hold
// expected load data and stream words.
`timescale 1ns/1ps
module tb_riscv_stream_mmio;
  localparam int unsigned NCH  = 4;
  localparam int unsigned DW   = 32;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mem_valid = 1'b0;
  logic [31:0]      mem_addr = '0;
  logic [31:0]      mem_wdata = '0;
  logic [3:0]       mem_wstrb = '0;
  logic             io_sel, io_ready;
  logic [31:0]      io_rdata;
  logic [NCH-1:0]   val_in = '0;
  logic [NCH*DW-1:0] din = '0;
  logic [NCH-1:0]   ready_upward, val_out, irq_rx;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]   ready_downward = '0;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] rd_exp_q[$];
  logic [31:0] rx_exp_q[$];
  logic [31:0] tx_exp_q[$];

  riscv_stream_mmio #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(8), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .io_sel(io_sel), .io_ready(io_ready),
    .io_rdata(io_rdata), .val_in(val_in), .din(din), .ready_upward(ready_upward),
    .val_out(val_out), .dout(dout), .ready_downward(ready_downward), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Issue one request from a negedge; returns at the negedge after the ack cycle
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    mem_addr  = addr;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io_ready) begin
        lat = i;
        rd  = io_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    @(negedge clk);
  endtask

  task automatic rx_push(input int ch, input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      val_in[ch] = 1'b1;
      din[ch*DW +: DW] = seed + 32'(i);
      rx_exp_q.push_back(seed + 32'(i));
      @(negedge clk);
    end
    val_in[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, want;
    int lat;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (ready_upward !== 4'hF) begin
      mismatched++; $display("FAIL reset_ready_upward got %h want f", ready_upward);
    end
    compared++;
    if (val_out !== 4'h0 || irq_rx !== 4'h0) begin
      mismatched++; $display("FAIL reset_val_irq got %h/%h want 0/0", val_out, irq_rx);
    end
    compared++;
    if (io_ready !== 1'b0 || io_rdata !== 32'h0 || dout !== '0) begin
      mismatched++; $display("FAIL reset_outputs got rdy=%b rdata=%h dout=%h want 0", io_ready,
                             io_rdata, dout);
    end
    mem_addr = BASE + 32'd64;
    mem_valid = 1'b1;
    #1;
    compared++;
    if (io_sel !== 1'b0) begin
      mismatched++; $display("FAIL sel_outside got %b want 0", io_sel);
    end
    mem_addr = BASE + 32'd40;
    #1;
    compared++;
    if (io_sel !== 1'b1) begin
      mismatched++; $display("FAIL sel_inside got %b want 1", io_sel);
    end
    mem_valid = 1'b0;
    rd_exp_q.push_back(32'h0000_0004);
    bus(BASE + 32'd40, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want || lat !== 1) begin
      mismatched++; $display("FAIL reset_status_ch2 got %h lat %0d want %h lat 1", rd, lat, want);
    end
  endtask

  task automatic test_tx_path();
    logic [31:0] rd, want;
    int lat;
    ready_downward = 4'b0010;
    tx_exp_q.push_back(32'hCAFE_0001);
    bus(BASE + 32'd16, 32'hCAFE_0001, 4'hF, rd, lat);
    compared++;
    if (lat !== 1) begin
      mismatched++; $display("FAIL tx_ack_latency got %0d want 1", lat);
    end
    want = tx_exp_q.pop_front();
    compared++;
    if (val_out !== 4'b0010 || dout[63:32] !== want || io_ready !== 1'b0) begin
      mismatched++; $display("FAIL tx_dout got val=%b dout=%h rdy=%b want 0010 %h 0", val_out,
                             dout[63:32], io_ready, want);
    end
    @(negedge clk);
    compared++;
    if (val_out[1] !== 1'b0) begin
      mismatched++; $display("FAIL tx_popped got val_out=%b want 0", val_out[1]);
    end
    ready_downward = '0;
  endtask

  task automatic test_rx_fill();
    logic [31:0] rd, want;
    int lat;
    rx_push(0, 8, 32'h1000_0000);
    compared++;
    if (ready_upward[0] !== 1'b0 || irq_rx[0] !== 1'b1) begin
      mismatched++; $display("FAIL rx_full got rdy=%b irq=%b want 0 1", ready_upward[0], irq_rx[0]);
    end
    rd_exp_q.push_back(32'h0000_0805);
    bus(BASE + 32'd8, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL rx_full_status got %h want %h", rd, want);
    end
    for (int i = 0; i < 8; i++) begin
      bus(BASE + 32'd4, 32'h0, 4'h0, rd, lat);
      want = rx_exp_q.pop_front();
      compared++;
      if (rd !== want || lat !== 1) begin
        mismatched++; $display("FAIL rx_fill_load%0d got %h lat %0d want %h lat 1", i, rd, lat,
                               want);
      end
      if (i == 0) begin
        compared++;
        if (ready_upward[0] !== 1'b1) begin
          mismatched++; $display("FAIL rx_ready_after_pop got %b want 1", ready_upward[0]);
        end
      end
    end
    compared++;
    if (irq_rx[0] !== 1'b0) begin
      mismatched++; $display("FAIL rx_irq_drained got %b want 0", irq_rx[0]);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [31:0] rd, want;
    int lat;
    rx_push(3, 6, 32'h3000_0000);
    for (int i = 0; i < 6; i++) begin
      bus(BASE + 32'd52, 32'h0, 4'h0, rd, lat);
      want = rx_exp_q.pop_front();
      compared++;
      if (rd !== want) begin
        mismatched++; $display("FAIL simul_pre%0d got %h want %h", i, rd, want);
      end
    end
    rx_push(3, 5, 32'h3100_0000);
    mem_addr  = BASE + 32'd52;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    @(negedge clk);
    want = rx_exp_q.pop_front();
    compared++;
    if (io_ready !== 1'b1 || io_rdata !== want) begin
      mismatched++; $display("FAIL simul_ack got rdy=%b %h want 1 %h", io_ready, io_rdata, want);
    end
    mem_valid = 1'b0;
    val_in[3] = 1'b1;
    din[127:96] = 32'h3200_0000;
    rx_exp_q.push_back(32'h3200_0000);
    @(negedge clk);
    val_in[3] = 1'b0;
    rd_exp_q.push_back(32'h0000_0505);
    bus(BASE + 32'd56, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL simul_count got %h want %h", rd, want);
    end
    for (int i = 0; i < 5; i++) begin
      bus(BASE + 32'd52, 32'h0, 4'h0, rd, lat);
      want = rx_exp_q.pop_front();
      compared++;
      if (rd !== want) begin
        mismatched++; $display("FAIL simul_drain%0d got %h want %h", i, rd, want);
      end
    end
  endtask

`ifndef STREAM_MMIO_BLOCKING_EN
  task automatic test_overflow();
    logic [31:0] rd, want;
    int lat;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp_q.push_back(32'hA000_0000 + 32'(i));
      bus(BASE, 32'hA000_0000 + 32'(i), 4'hF, rd, lat);
      compared++;
      if (lat !== 1) begin
        mismatched++; $display("FAIL ovf_store%0d latency got %0d want 1", i, lat);
      end
    end
    rd_exp_q.push_back(32'h0008_000A);
    bus(BASE + 32'd8, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL ovf_status got %h want %h", rd, want);
    end
    bus(BASE + 32'd8, 32'h8, 4'hF, rd, lat);
    rd_exp_q.push_back(32'h0008_0002);
    bus(BASE + 32'd8, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL ovf_clear got %h want %h", rd, want);
    end
    ready_downward[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = tx_exp_q.pop_front();
      compared++;
      if (val_out[0] !== 1'b1 || dout[31:0] !== want) begin
        mismatched++; $display("FAIL ovf_drain%0d got val=%b %h want 1 %h", i, val_out[0],
                               dout[31:0], want);
      end
      @(negedge clk);
    end
    compared++;
    if (val_out[0] !== 1'b0) begin
      mismatched++; $display("FAIL ovf_dropped got val_out=%b want 0", val_out[0]);
    end
    ready_downward = '0;
  endtask

  task automatic test_underflow();
    logic [31:0] rd, want;
    int lat;
    rd_exp_q.push_back(32'h0);
    bus(BASE + 32'd20, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want || lat !== 1) begin
      mismatched++; $display("FAIL udf_load got %h lat %0d want %h lat 1", rd, lat, want);
    end
    rd_exp_q.push_back(32'h0000_0014);
    bus(BASE + 32'd24, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL udf_status got %h want %h", rd, want);
    end
    bus(BASE + 32'd24, 32'h10, 4'hF, rd, lat);
    rd_exp_q.push_back(32'h0000_0004);
    bus(BASE + 32'd24, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL udf_clear got %h want %h", rd, want);
    end
  endtask
`endif

  task automatic test_misc();
    logic [31:0] rd, want;
    int lat;
    rx_push(2, 1, 32'h2222_0000);
    rd_exp_q.push_back(32'h0);
    bus(BASE + 32'd44, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want || lat !== 1) begin
      mismatched++; $display("FAIL reserved_read got %h lat %0d want %h lat 1", rd, lat, want);
    end
    rd_exp_q.push_back(32'h0);
    bus(BASE + 32'd32, 32'h0, 4'h0, rd, lat);
    want = rd_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL tx_reg_read got %h want %h", rd, want);
    end
    bus(BASE + 32'd36, 32'hDEAD_BEEF, 4'hF, rd, lat);
    bus(BASE + 32'd36, 32'h0, 4'h0, rd, lat);
    want = rx_exp_q.pop_front();
    compared++;
    if (rd !== want) begin
      mismatched++; $display("FAIL rx_store_ignored got %h want %h", rd, want);
    end
  endtask

`ifdef STREAM_MMIO_BLOCKING_EN
  task automatic test_blocking();
    logic [31:0] want;
    int acks;
    mem_addr  = BASE + 32'd20;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (io_ready) acks++;
    end
    compared++;
    if (acks !== 0) begin
      mismatched++; $display("FAIL blk_stall got %0d acks want 0", acks);
    end
    val_in[1] = 1'b1;
    din[63:32] = 32'h55;
    rx_exp_q.push_back(32'h55);
    @(negedge clk);
    val_in[1] = 1'b0;
    compared++;
    if (io_ready !== 1'b0) begin
      mismatched++; $display("FAIL blk_early got %b want 0", io_ready);
    end
    @(negedge clk);
    want = rx_exp_q.pop_front();
    compared++;
    if (io_ready !== 1'b1 || io_rdata !== want) begin
      mismatched++; $display("FAIL blk_release got rdy=%b %h want 1 %h", io_ready, io_rdata, want);
    end
    mem_valid = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    acks = 0;
    repeat (3) begin @(negedge clk); if (io_ready) acks++; end
    reset = 1'b1;
    repeat (2) begin @(negedge clk); if (io_ready) acks++; end
    reset = 1'b0;
    repeat (2) begin @(negedge clk); if (io_ready) acks++; end
    compared++;
    if (acks !== 0) begin
      mismatched++; $display("FAIL blk_reset_ack got %0d acks want 0", acks);
    end
    val_in[1] = 1'b1;
    din[63:32] = 32'h66;
    rx_exp_q.push_back(32'h66);
    @(negedge clk);
    val_in[1] = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io_ready) begin acks = 1; break; end
    end
    want = rx_exp_q.pop_front();
    compared++;
    if (acks !== 1 || io_rdata !== want) begin
      mismatched++; $display("FAIL blk_after_reset got ack=%0d %h want 1 %h", acks, io_rdata, want);
    end
    mem_valid = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_tx_path();
    test_rx_fill();
    test_simul_push_pop();
`ifndef STREAM_MMIO_BLOCKING_EN
    test_overflow();
    test_underflow();
`endif
    test_misc();
`ifdef STREAM_MMIO_BLOCKING_EN
    test_blocking();
`endif
    compared++;
    if (rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      mismatched++; $display("FAIL scoreboard_leftover got rx=%0d tx=%0d want 0 0",
                             rx_exp_q.size(), tx_exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
